// File: rtl/llsc_unit.sv
`default_nettype none
// ============================================================================
// Module      : llsc_unit
// Description : Execute-stage LL.W / SC.W unit. Owns the LLbit and the
//               reserved word address, issues one memory request at a time
//               and returns one writeback result per accepted instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module llsc_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        atomic_op_type,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic              llbit_clear,
    input  logic              flush,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              ale,
    output logic              llbit
);

    // Atomic decoder encodings
    localparam logic [1:0] c_INVALID_OP_2B = 2'b00;
    localparam logic [1:0] c_ATOMIC_LL     = 2'b01;
    localparam logic [1:0] c_ATOMIC_SC     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_WB    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_llbit;
    logic [ADDR_W-3:0]   r_ll_addr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [4:0]          r_rd;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_ale;

    logic                w_is_ll;
    logic                w_is_sc;
    logic                w_accept;
    logic                w_misalign;
    logic                w_sc_hit;
    logic                w_handshake;
    logic                w_snoop_hit;
    logic                w_ll_set;
    logic                w_sc_clr;
    logic                w_unused;

    // The low snoop address bits never matter: reservations are word-granular.
    assign w_unused    = &{1'b0, snoop_addr[1:0]};

    assign w_is_ll     = (atomic_op_type == c_ATOMIC_LL);
    assign w_is_sc     = (atomic_op_type == c_ATOMIC_SC);
    // A flush in IDLE blocks acceptance; INVALID_OP_2B (and any unknown code) is ignored.
    assign w_accept    = in_valid && (r_state == S_IDLE) && (w_is_ll || w_is_sc)
                         && (atomic_op_type != c_INVALID_OP_2B) && !flush;
    assign w_misalign  = (in_addr[1:0] != 2'b00);
    // SC success is decided on the registered LLbit, so a same-cycle snoop cannot affect it.
    assign w_sc_hit    = r_llbit && (in_addr[ADDR_W-1:2] == r_ll_addr);
    assign w_handshake = (r_state == S_REQ) && mem_req_ready;
    assign w_snoop_hit = snoop_valid && (snoop_addr[ADDR_W-1:2] == r_ll_addr);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the LLbit set/clear strobes tied to transitions
    always_comb begin
        w_state_nxt = r_state;
        w_ll_set    = 1'b0;
        w_sc_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_misalign) begin
                    if (w_is_ll || w_sc_hit) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        // Failing SC: no request, straight to writeback of 0.
                        w_state_nxt = S_WB;
                        w_sc_clr    = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    // A request that handshakes in the flush cycle still owes a response.
                    w_state_nxt = w_handshake ? S_DRAIN : S_IDLE;
                    w_sc_clr    = w_handshake && r_we;
                end else if (w_handshake) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = flush ? S_IDLE : S_WB;
                    w_sc_clr    = r_we;
                    w_ll_set    = !r_we && !flush;
                end else if (flush) begin
                    w_state_nxt = S_DRAIN;
                    w_sc_clr    = r_we;
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Instruction latch, writeback data and misalignment pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_rd      <= '0;
            r_wb_data <= '0;
            r_ale     <= 1'b0;
        end else begin
            r_ale <= w_accept && w_misalign;
            if (w_accept && !w_misalign) begin
                r_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                r_wdata <= in_wdata;
                r_we    <= w_is_sc;
                r_rd    <= in_rd;
                if (w_is_sc && !w_sc_hit) begin
                    r_wb_data <= '0;
                end
            end
            if ((r_state == S_WAIT) && mem_resp_valid) begin
                r_wb_data <= r_we ? {{(DATA_W-1){1'b0}}, 1'b1} : mem_resp_rdata;
            end
        end
    end

    // LLbit: llbit_clear beats the LL set, which beats snoop and SC clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_llbit   <= 1'b0;
            r_ll_addr <= '0;
        end else begin
            if (llbit_clear) begin
                r_llbit <= 1'b0;
            end else if (w_ll_set) begin
                r_llbit <= 1'b1;
            end else if (w_sc_clr || w_snoop_hit) begin
                r_llbit <= 1'b0;
            end
            if (w_ll_set) begin
                r_ll_addr <= r_addr[ADDR_W-1:2];
            end
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign wb_valid      = (r_state == S_WB) && !flush;
    assign wb_rd         = r_rd;
    assign wb_data       = r_wb_data;
    assign ale           = r_ale;
    assign llbit         = r_llbit;

endmodule
`default_nettype wire

// File: tb/tb_llsc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_llsc_unit
// Description : Self-checking bench for llsc_unit. Random LL/SC traffic with a
//               transaction-level reservation model and a bench-side memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llsc_unit;

    localparam logic [1:0] c_INV = 2'b00;
    localparam logic [1:0] c_LL  = 2'b01;
    localparam logic [1:0] c_SC  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  atomic_op_type;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        llbit_clear;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ale;
    logic        llbit;

    int n_tests = 0;
    int n_fail  = 0;

    // Reservation model: architectural LLbit and reserved word address
    bit          m_llbit  = 1'b0;
    logic [29:0] m_lladdr = '0;

    llsc_unit #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .atomic_op_type (atomic_op_type),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_rd          (in_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .snoop_valid    (snoop_valid),
        .snoop_addr     (snoop_addr),
        .llbit_clear    (llbit_clear),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .ale            (ale),
        .llbit          (llbit)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        return (a * 32'h0100_0193) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_1000;
            1:       return 32'h0000_1004;
            2:       return 32'h0000_2000;
            default: return 32'h0000_3000;
        endcase
    endfunction

    // fmode: 0 none, 1 flush while waiting for the response (or in WB for a
    // failing SC), 2 flush while the request is still unacknowledged.
    task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int fmode, input bit snp, input bit clr);
        bit is_ll, is_sc, mis, succ, issues;
        bit req_pend, waiting, flushed, wb_due, done;
        int cnt;
        logic [31:0] al;
        is_ll  = (op == c_LL);
        is_sc  = (op == c_SC);
        mis    = (addr[1:0] != 2'b00);
        succ   = is_sc && m_llbit && (addr[31:2] == m_lladdr);
        issues = (is_ll || succ) && !mis;
        al     = {addr[31:2], 2'b00};

        check_eq("in_ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; atomic_op_type = op; in_addr = addr; in_wdata = wd; in_rd = rd;
        if (snp) begin
            snoop_valid = 1'b1;
            snoop_addr  = {m_lladdr, 2'b01};
        end
        @(negedge clk);
        in_valid = 1'b0; snoop_valid = 1'b0; atomic_op_type = c_INV;
        if (snp) m_llbit = 1'b0;

        if (!(is_ll || is_sc)) begin
            check_eq("inv_req", {31'd0, mem_req_valid}, 32'd0);
            check_eq("inv_wb", {31'd0, wb_valid}, 32'd0);
            check_eq("inv_ale", {31'd0, ale}, 32'd0);
            check_eq("inv_ready", {31'd0, in_ready}, 32'd1);
            return;
        end
        if (mis) begin
            check_eq("ale_pulse", {31'd0, ale}, 32'd1);
            check_eq("ale_req", {31'd0, mem_req_valid}, 32'd0);
            check_eq("ale_wb", {31'd0, wb_valid}, 32'd0);
            @(negedge clk);
            check_eq("ale_off", {31'd0, ale}, 32'd0);
            check_eq("ale_ready", {31'd0, in_ready}, 32'd1);
            return;
        end
        if (!issues) begin
            if (fmode != 0) begin
                flush = 1'b1;
                #1;
                check_eq("scfail_wb_flushed", {31'd0, wb_valid}, 32'd0);
            end else begin
                check_eq("scfail_wb", {31'd0, wb_valid}, 32'd1);
                check_eq("scfail_data", wb_data, 32'd0);
                check_eq("scfail_rd", {27'd0, wb_rd}, {27'd0, rd});
            end
            check_eq("scfail_req", {31'd0, mem_req_valid}, 32'd0);
            m_llbit = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            check_eq("scfail_wb_end", {31'd0, wb_valid}, 32'd0);
            check_eq("scfail_ready", {31'd0, in_ready}, 32'd1);
            return;
        end

        req_pend = 1'b1; waiting = 1'b0; flushed = 1'b0; wb_due = 1'b0; done = 1'b0; cnt = 0;
        for (int g = 0; g < 60 && !done; g++) begin
            check_eq("req_valid", {31'd0, mem_req_valid}, {31'd0, req_pend});
            if (req_pend) begin
                check_eq("req_we", {31'd0, mem_req_we}, {31'd0, is_sc});
                check_eq("req_addr", mem_req_addr, al);
                if (is_sc) check_eq("req_wdata", mem_req_wdata, wd);
            end
            check_eq("wb_valid", {31'd0, wb_valid}, {31'd0, wb_due});
            if (wb_due) begin
                check_eq("wb_data", wb_data, is_sc ? 32'd1 : mem_word(al));
                check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
                done = 1'b1;
                if (is_ll) begin
                    m_llbit  = !clr;
                    m_lladdr = addr[31:2];
                end else begin
                    m_llbit = 1'b0;
                end
            end else if (req_pend) begin
                if (fmode == 2) begin
                    flush = 1'b1;
                    done  = 1'b1;
                end else if ($urandom_range(0, 1) == 1) begin
                    mem_req_ready = 1'b1;
                    req_pend = 1'b0;
                    waiting  = 1'b1;
                    cnt = (fmode == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
                end
            end else if (waiting) begin
                if (cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mem_word(al);
                    waiting = 1'b0;
                    if (flushed) begin
                        done = 1'b1;
                        if (is_sc) m_llbit = 1'b0;
                    end else begin
                        wb_due = 1'b1;
                        if (clr) llbit_clear = 1'b1;
                    end
                end else begin
                    cnt--;
                    if (fmode == 1 && !flushed) begin
                        flush   = 1'b1;
                        flushed = 1'b1;
                    end
                end
            end
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; flush = 1'b0; llbit_clear = 1'b0;
            mem_resp_rdata = $urandom;
        end
        if (!done) check_eq("timeout", 32'd1, 32'd0);
        check_eq("post_wb", {31'd0, wb_valid}, 32'd0);
        check_eq("post_req", {31'd0, mem_req_valid}, 32'd0);
        check_eq("post_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic idle_cycle(input bit snp, input logic [31:0] saddr, input bit clr);
        snoop_valid = snp; snoop_addr = saddr; llbit_clear = clr;
        @(negedge clk);
        snoop_valid = 1'b0; llbit_clear = 1'b0;
        if (clr || (snp && saddr[31:2] == m_lladdr)) m_llbit = 1'b0;
    endtask

    task automatic blocked_accept(input logic [31:0] addr);
        in_valid = 1'b1; atomic_op_type = c_LL; in_addr = addr; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; atomic_op_type = c_INV; flush = 1'b0;
        check_eq("blk_req", {31'd0, mem_req_valid}, 32'd0);
        check_eq("blk_ready", {31'd0, in_ready}, 32'd1);
        check_eq("blk_wb", {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic check_llbit();
        check_eq("llbit", {31'd0, llbit}, {31'd0, m_llbit});
    endtask

    initial begin
        logic [1:0]  lo;
        logic [31:0] a;
        int          k;
        rst = 1'b1;
        in_valid = 1'b0; atomic_op_type = c_INV; in_addr = '0; in_wdata = '0; in_rd = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        snoop_valid = 1'b0; snoop_addr = '0; llbit_clear = 1'b0; flush = 1'b0;
        #12;
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_req", {31'd0, mem_req_valid}, 32'd0);
        check_eq("rst_wb", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_ale", {31'd0, ale}, 32'd0);
        check_eq("rst_llbit", {31'd0, llbit}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_op(c_LL, 32'h1000, 32'h0, 5'd3, 0, 1'b0, 1'b0);  check_llbit();
        run_op(c_SC, 32'h1000, 32'h55, 5'd4, 0, 1'b0, 1'b0); check_llbit();
        run_op(c_LL, 32'h1000, 32'h0, 5'd5, 0, 1'b0, 1'b0);  check_llbit();
        idle_cycle(1'b1, 32'h1002, 1'b0);                     check_llbit();
        run_op(c_SC, 32'h1000, 32'h66, 5'd6, 0, 1'b0, 1'b0); check_llbit();
        run_op(c_LL, 32'h2000, 32'h0, 5'd7, 0, 1'b0, 1'b0);  check_llbit();
        run_op(c_SC, 32'h2004, 32'h77, 5'd8, 0, 1'b0, 1'b0); check_llbit();
        run_op(c_SC, 32'h2000, 32'h88, 5'd9, 0, 1'b0, 1'b0); check_llbit();
        run_op(c_LL, 32'h1001, 32'h0, 5'd10, 0, 1'b0, 1'b0); check_llbit();
        run_op(c_LL, 32'h3000, 32'h0, 5'd11, 1, 1'b0, 1'b0); check_llbit();
        run_op(c_LL, 32'h3000, 32'h0, 5'd12, 0, 1'b0, 1'b1); check_llbit();
        run_op(c_LL, 32'h1004, 32'h0, 5'd13, 0, 1'b0, 1'b0); check_llbit();
        run_op(c_SC, 32'h1004, 32'h99, 5'd14, 0, 1'b1, 1'b0); check_llbit();
        run_op(c_INV, 32'h1000, 32'h0, 5'd15, 0, 1'b0, 1'b0);
        blocked_accept(32'h1000);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 3) begin
                k = $urandom_range(0, 5);
                run_op(c_LL, pick_addr(), 32'h0, 5'($urandom), (k == 4) ? 1 : (k == 5) ? 2 : 0,
                       1'b0, $urandom_range(0, 7) == 0);
            end else if (k <= 6) begin
                a = ($urandom_range(0, 2) != 0) ? {m_lladdr, 2'b00} : pick_addr();
                k = $urandom_range(0, 5);
                run_op(c_SC, a, $urandom, 5'($urandom), (k == 4) ? 1 : (k == 5) ? 2 : 0,
                       $urandom_range(0, 4) == 0, 1'b0);
            end else if (k == 7) begin
                lo = 2'($urandom_range(1, 3));
                a  = pick_addr() | {30'd0, lo};
                run_op($urandom_range(0, 1) ? c_LL : c_SC, a, $urandom, 5'($urandom), 0, 1'b0, 1'b0);
            end else if (k == 8) begin
                run_op(c_INV, pick_addr(), $urandom, 5'($urandom), 0, 1'b0, 1'b0);
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    blocked_accept(pick_addr());
                end else begin
                    lo = 2'($urandom);
                    a  = $urandom_range(0, 1) ? {m_lladdr, lo} : pick_addr();
                    idle_cycle($urandom_range(0, 1) == 1, a, $urandom_range(0, 9) == 0);
                end
            end
            check_llbit();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/llsc_unit.md
Name: llsc_unit

Overview:
- Execute-stage unit that consumes `atomic_op_type` from the atomic decoder and carries out LoongArch LL.W/SC.W.
- Holds the architectural LLbit and the reserved word address.
- Issues single-word requests to the data-memory port and returns one writeback result per accepted instruction.
- Address (base + offset) is computed upstream and arrives already formed.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  unit can accept; high only in IDLE.
- atomic_op_type  input  2  `ATOMIC_LL` / `ATOMIC_SC` / `INVALID_OP_2B` (defs.sv encodings).
- in_addr  input  ADDR_W  effective byte address.
- in_wdata  input  DATA_W  SC store data.
- in_rd  input  5  destination register.
- mem_req_valid  output  1  memory request.
- mem_req_ready  input  1  memory accepts request.
- mem_req_we  output  1  1 = write (SC), 0 = read (LL).
- mem_req_addr  output  ADDR_W  word-aligned request address.
- mem_req_wdata  output  DATA_W  write data.
- mem_resp_valid  input  1  read data valid / write acknowledged.
- mem_resp_rdata  input  DATA_W  read data.
- snoop_valid  input  1  another store committed this cycle.
- snoop_addr  input  ADDR_W  address of that store.
- llbit_clear  input  1  exception or ERTN; clears LLbit.
- flush  input  1  pipeline flush; abort the in-flight instruction.
- wb_valid  output  1  one-cycle writeback pulse.
- wb_rd  output  5  destination register.
- wb_data  output  DATA_W  LL load data, or SC result (0 or 1).
- ale  output  1  one-cycle misaligned-address exception pulse.
- llbit  output  1  current LLbit.

Behaviour:
- Reset:
  - state = IDLE; llbit = 0; ll_addr = 0.
  - mem_req_valid = 0; wb_valid = 0; ale = 0; wb_data = 0; wb_rd = 0.
- States: IDLE, REQ, WAIT, DRAIN, WB. Accept = in_valid & in_ready & op != INVALID_OP_2B.
- Invalid op: in_valid with INVALID_OP_2B is ignored and produces no output.
- Misaligned (in_addr[1:0] != 0) on accept:
  - ale pulses the next cycle; no memory request; no wb; LLbit unchanged.
  - State returns to IDLE.
- LL accept: latch rd and addr, go to REQ.
  - REQ: mem_req_valid = 1, we = 0.
    - Address and data held stable until mem_req_ready.
    - REQ→WAIT on handshake.
  - WAIT: on mem_resp_valid, set llbit = 1 and ll_addr = addr[31:2], latch rdata, go to WB.
- SC accept:
  - If llbit = 1 and in_addr[31:2] == ll_addr: go to REQ with we = 1, data = in_wdata. On resp → WB with wb_data = 1.
  - Otherwise: no request; go directly to WB with wb_data = 0.
  - Every SC clears llbit in the cycle it enters WB, success or fail.
- WB: wb_valid = 1 for exactly one cycle with wb_rd/wb_data, then IDLE. in_ready stays low in WB.
- Minimum latency for LL, or SC that succeeds:
  - accept at cycle 0; request at cycle 1; response at cycle N.
  - wb_valid at cycle N+1.
- Failing SC: wb_valid at cycle 1.
- Snoop: snoop_valid with snoop_addr[31:2] == ll_addr clears llbit.
- LLbit priority, highest first:
  1. rst
  2. llbit_clear
  3. LL response set
  4. snoop clear / SC clear
- SC with pending snoop: SC compare uses registered llbit. A snoop in the same cycle as SC accept does not affect that SC.
- Flush:
  - In REQ before handshake (including a handshake in the same cycle as flush): if handshake did not occur, go to IDLE with no wb. If it did occur, go to DRAIN.
  - In WAIT: go to DRAIN. DRAIN absorbs one mem_resp_valid, then goes to IDLE, with no wb and no llbit set.
  - A flushed SC that already issued its write still clears llbit.
  - In WB: wb_valid is suppressed.
  - flush in IDLE blocks acceptance that cycle.
- Only one outstanding request at a time. mem_resp_valid in IDLE/REQ/WB is ignored.
- mem_req_addr[1:0] is always 0.

Test Plan:
- LL 0x1000, mem returns 0xDEADBEEF with ready at cycle 1 and resp at cycle 3 → wb_valid at cycle 4; wb_data = 0xDEADBEEF; llbit = 1.
- LL 0x1000 then SC 0x1000 data 0x55 → write request with addr 0x1000, wdata 0x55; wb_data = 1; llbit = 0 after.
- LL 0x1000, snoop_valid with addr 0x1002, then SC 0x1000 → no mem request; wb_data = 0 one cycle after accept.
- LL 0x2000 then SC 0x2004 → no request; wb_data = 0; llbit cleared. Also: SC with llbit = 0 → wb_data = 0.
- LL 0x1001 → ale pulse; no mem_req_valid; llbit unchanged.
- LL 0x3000, flush during WAIT → response drained; no wb_valid; llbit stays 0; next LL accepted normally. Also: llbit_clear in the same cycle as the LL response → llbit = 0.
